// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy-bit scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.

module regfile_mp_rdport #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic                      i_vld,
  input  logic [AW-1:0]             i_addr,
  input  logic [XLEN-1:0]           i_data,
  input  logic                      i_busy,
  input  logic [NWR-1:0]            i_wr_en,
  input  logic [NWR-1:0][AW-1:0]    i_wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]  i_wr_data,
  output logic [XLEN-1:0]           o_data,
  output logic                      o_busy
);

`ifdef REGFILE_BYPASS_EN
  // Ascending scan so the youngest (highest-index) matching write wins.
  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_vld) begin
      o_data = i_data;
      o_busy = i_busy;
      for (int i = 0; i < NWR; i++) begin
        if (i_wr_en[i] && (i_wr_addr[i] == i_addr)) begin
          o_data = i_wr_data[i];
          o_busy = 1'b0;
        end
      end
    end
  end
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    if (i_vld) begin
      o_data = i_data;
      o_busy = i_busy;
    end
  end
`endif

endmodule

module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*XLEN-1:0]   wr_data,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  clm_en,
  input  logic [AW-1:0]         clm_addr
);

  localparam int              DEPTH  = 1 << AW;
  localparam logic [AW:0]     NREG_A = (AW+1)'(NREG);
  localparam logic [AW-1:0]   LAST   = AW'(NREG-1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wreq_t;

  state_t                    r_state, w_state_nxt;
  logic [AW-1:0]             r_cnt;
  logic [XLEN-1:0]           r_regs [DEPTH];
  logic [DEPTH-1:0]          r_busy;
  logic [DEPTH-1:0]          w_busy_nxt;
  logic                      w_run;
  logic                      w_clm_ok;

  logic [NWR-1:0][AW-1:0]    w_wr_addr;
  logic [NWR-1:0][XLEN-1:0]  w_wr_data;
  wreq_t [NWR-1:0]           w_wreq;
  logic [NWR-1:0]            w_wr_ok;

  logic [NRD-1:0][AW-1:0]    w_rd_addr;
  logic [NRD-1:0][XLEN-1:0]  w_rd_stored;
  logic [NRD-1:0]            w_rd_sbusy;
  logic [NRD-1:0]            w_rd_vld;
  logic [NRD-1:0][XLEN-1:0]  w_rd_data;

  assign w_wr_addr = wr_addr;
  assign w_wr_data = wr_data;
  assign w_rd_addr = rd_addr;
  assign rd_data   = w_rd_data;
  assign w_run     = (r_state == S_RUN);
  assign ready     = w_run;

  // Writes and claims only take effect in RUN, to nonzero in-range addresses.
  genvar gi;
  generate
    for (gi = 0; gi < NWR; gi++) begin : g_wr
      assign w_wreq[gi].en   = wr_en[gi] && w_run && (w_wr_addr[gi] != '0) &&
                               ({1'b0, w_wr_addr[gi]} < NREG_A);
      assign w_wreq[gi].addr = w_wr_addr[gi];
      assign w_wreq[gi].data = w_wr_data[gi];
      assign w_wr_ok[gi]     = w_wreq[gi].en;
    end
  endgenerate

  assign w_clm_ok = clm_en && w_run && (clm_addr != '0) &&
                    ({1'b0, clm_addr} < NREG_A);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_cnt == LAST) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Claim is applied after the write clears: it is the younger event.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NWR; i++) begin
      if (w_wr_ok[i]) w_busy_nxt[w_wreq[i].addr] = 1'b0;
    end
    if (w_clm_ok) w_busy_nxt[clm_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Storage has no reset so it can map to RAM; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_INIT) begin
        r_regs[r_cnt] <= '0;
      end else begin
        for (int i = 0; i < NWR; i++) begin
          if (w_wr_ok[i]) r_regs[w_wreq[i].addr] <= w_wreq[i].data;
        end
      end
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < NRD; gj++) begin : g_rd
      assign w_rd_vld[gj]    = rd_en[gj] && w_run && (w_rd_addr[gj] != '0) &&
                               ({1'b0, w_rd_addr[gj]} < NREG_A);
      assign w_rd_stored[gj] = r_regs[w_rd_addr[gj]];
      assign w_rd_sbusy[gj]  = r_busy[w_rd_addr[gj]];

      regfile_mp_rdport #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_rdport (
        .i_vld     (w_rd_vld[gj]),
        .i_addr    (w_rd_addr[gj]),
        .i_data    (w_rd_stored[gj]),
        .i_busy    (w_rd_sbusy[gj]),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .o_data    (w_rd_data[gj]),
        .o_busy    (rd_busy[gj])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: reset sweep, vector table, bypass and mid-run reset.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ready;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*XLEN-1:0]  wr_data;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 clm_en;
  logic [AW-1:0]        clm_addr;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .clm_en(clm_en), .clm_addr(clm_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        ce;
    logic [4:0]  ca;
    logic [31:0] ed0, ed1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl [12];
  vec_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic [1:0] re,
                              logic [4:0] ra0, logic [4:0] ra1, logic ce, logic [4:0] ca,
                              logic [31:0] ed0, logic [31:0] ed1, logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.ce = ce; v.ca = ca;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0; clm_en = 1'b0; clm_addr = '0;
  endtask

  // Drive one cycle of stimulus, score the combinational reads, advance to next cycle.
  task automatic run_vec(input vec_t v, input string nm);
    vec_t e;
    wr_en = v.we; wr_addr = {v.wa1, v.wa0}; wr_data = {v.wd1, v.wd0};
    rd_en = v.re; rd_addr = {v.ra1, v.ra0};
    clm_en = v.ce; clm_addr = v.ca;
    exp_q.push_back(v);
    #3;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_d0"}, rd_data[31:0],  e.ed0);
      chk({nm, "_d1"}, rd_data[63:32], e.ed1);
      chk({nm, "_busy"}, {30'd0, rd_busy}, {30'd0, e.eb});
    end
    @(posedge clk); #1;
    idle();
  endtask

  // Counts ready-low cycles while trying to write/claim x5, checking reads stay 0.
  task automatic sweep(input string nm);
    int zc = 0;
    int bad = 0;
    while (!ready && zc < 100) begin
      wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'hBAD0BAD1, 32'hBAD0BAD0};
      clm_en = 1'b1; clm_addr = 5'd5;
      rd_en = 2'b11; rd_addr = {5'd5, 5'd1};
      #2;
      if (rd_data !== '0 || rd_busy !== '0) bad++;
      @(posedge clk); #1;
      zc++;
    end
    idle();
    chk({nm, "_ready_lat"}, zc, 31);
    chk({nm, "_init_rd0"}, bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_en = 2'b11; rd_addr = {5'd6, 5'd5};
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rd", rd_data[31:0] | rd_data[63:32], 32'd0);
    chk("rst_busy", {30'd0, rd_busy}, 32'd0);
    rst = 1'b0;

    sweep("sweep1");
    chk("ready_up", {31'd0, ready}, 32'd1);

    for (int r = 0; r < NREG; r += 2)
      run_vec(mk(2'b00, 0, 0, 0, 0, 2'b11, 5'(r), 5'(r+1), 1'b0, 0, 0, 0, 2'b00),
              $sformatf("zero_x%0d", r));

    tbl[0]  = mk(2'b11, 7, 32'h11111111, 7, 32'h22222222, 2'b11, 1, 2, 0, 0, 0, 0, 2'b00);
    tbl[1]  = mk(2'b01, 0, 32'hDEADBEEF, 0, 0, 2'b11, 7, 0, 1, 0, 32'h22222222, 0, 2'b00);
    tbl[2]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 0, 3, 1, 3, 0, 0, 2'b00);
    tbl[3]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 0, 0, 2'b11);
    tbl[4]  = mk(2'b10, 0, 0, 3, 32'h5, 2'b11, 7, 1, 0, 0, 32'h22222222, 0, 2'b00);
    tbl[5]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 32'h5, 32'h5, 2'b00);
    tbl[6]  = mk(2'b01, 3, 32'h6, 0, 0, 2'b11, 7, 2, 1, 3, 32'h22222222, 0, 2'b00);
    tbl[7]  = mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 0, 0, 0, 32'h6, 0, 2'b01);
    tbl[8]  = mk(2'b01, 4, 32'h44, 0, 0, 2'b11, 3, 7, 1, 4, 32'h6, 32'h22222222, 2'b01);
    tbl[9]  = mk(2'b00, 0, 0, 0, 0, 2'b01, 4, 4, 0, 0, 32'h44, 0, 2'b01);
    tbl[10] = mk(2'b11, 10, 32'hA, 11, 32'hB, 2'b11, 4, 3, 0, 0, 32'h44, 32'h6, 2'b11);
    tbl[11] = mk(2'b00, 0, 0, 0, 0, 2'b11, 10, 11, 0, 0, 32'hA, 32'hB, 2'b00);
    for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Bypass: x9 is claimed first so the stored busy bit is set during the write cycle.
    run_vec(mk(2'b00, 0, 0, 0, 0, 2'b11, 7, 3, 1, 9, 32'h22222222, 32'h6, 2'b10), "byp_pre");
`ifdef REGFILE_BYPASS_EN
    run_vec(mk(2'b10, 0, 0, 9, 32'hCAFEF00D, 2'b11, 9, 9, 0, 0,
               32'hCAFEF00D, 32'hCAFEF00D, 2'b00), "byp_same");
`else
    run_vec(mk(2'b10, 0, 0, 9, 32'hCAFEF00D, 2'b11, 9, 9, 0, 0, 0, 0, 2'b11), "byp_same");
`endif
    run_vec(mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0,
               32'hCAFEF00D, 32'hCAFEF00D, 2'b00), "byp_next");

    // Mid-run reset with x4 busy and holding 0x44; the write in the reset cycle is dropped.
    rst = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'h99};
    rd_en = 2'b11; rd_addr = {5'd4, 5'd4};
    @(posedge clk); #1;
    rst = 1'b0;
    wr_en = '0;
    chk("mrst_ready", {31'd0, ready}, 32'd0);
    chk("mrst_busy", {30'd0, rd_busy}, 32'd0);
    chk("mrst_rd", rd_data[31:0], 32'd0);
    idle();
    sweep("sweep2");
    run_vec(mk(2'b00, 0, 0, 0, 0, 2'b11, 4, 7, 0, 0, 0, 0, 2'b00), "mrst_x4");
    run_vec(mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 5, 0, 0, 0, 0, 2'b00), "mrst_x9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with an integrated busy-bit scoreboard, the successor to the CPU's single-write, dual-read register file. It provides NRD combinational read ports, NWR write ports with fixed priority, optional same-cycle write-to-read forwarding, and a per-register pending bit so decode can detect RAW hazards on results that have not been written back yet. After reset, a sweep FSM clears the storage one entry per cycle so the array can map onto RAM-style storage. It sits between decode (reads, claims) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of registers; register 0 is hardwired zero
- AW, 5, address width; must satisfy 2^AW >= NREG
- NRD, 2, number of read ports
- NWR, 2, number of write ports; a higher index is a younger result and wins

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ready  out  1  high when the array is initialised and in RUN state
- wr_en  in  NWR  per-port write strobe
- wr_addr  in  NWR*AW  write addresses; port i occupies bits [i*AW +: AW]
- wr_data  in  NWR*XLEN  write data; port i occupies bits [i*XLEN +: XLEN]
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses, packed the same way as wr_addr
- rd_data  out  NRD*XLEN  read data, combinational
- rd_busy  out  NRD  the addressed register has an outstanding claim
- clm_en  in  1  issue-time claim: set the busy bit of clm_addr
- clm_addr  in  AW  destination register being claimed

## Operation
- State INIT: entered on any cycle with rst high.
  - rst high: sweep counter = 1; all busy bits are cleared in the same edge.
  - Each INIT cycle with rst low: regs[cnt] <= 0, then cnt++.
  - After regs[NREG-1] is cleared, go to RUN and set ready = 1.
  - During INIT: wr_en and clm_en are ignored, rd_data = 0, rd_busy = 0.
- State RUN: stays in RUN until rst is asserted.
- Writes:
  - Each enabled port with an address other than 0 writes at the edge.
  - Two or more ports to the same address in one cycle: the highest-index port's data is stored.
  - A write to register 0 is discarded.
- Busy bits:
  - An enabled write to address a clears busy[a].
  - clm_en sets busy[clm_addr].
  - Claim and write to the same address in one cycle: busy ends set (the claim is the younger event).
  - A claim to register 0 is ignored; busy[0] is always 0.
- Read port j:
  - rd_en low or address 0: rd_data = 0, rd_busy = 0.
  - Otherwise rd_data = regs[addr] and rd_busy = busy[addr], subject to forwarding (see Configuration).
  - A same-cycle claim never affects rd_busy; it applies from the next cycle.
- Addresses >= NREG: reads return 0 and busy 0; writes and claims are ignored.

## Timing
- Reset values: ready = 0, all rd_data = 0, all rd_busy = 0, all busy bits = 0. Register contents are zero only after the sweep completes.
- ready rises exactly NREG-1 cycles after the first rst-low cycle.
- Reads are combinational, with zero latency from address to data.
- A write is visible through storage at the cycle after its edge.
- Reset asserted mid-sweep or mid-RUN restarts INIT on the next edge. In-flight writes in the reset cycle are dropped.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If an enabled write to the same nonzero address is present in the same cycle, rd_data returns that write's data. The highest-index matching port wins.
  - rd_busy = 0 whenever a same-cycle write matches.
- REGFILE_BYPASS_EN undefined:
  - rd_data and rd_busy reflect stored state only.
  - Same-cycle writes become visible on the next cycle.

## Test plan
- Reset sweep: rst for 1 cycle with NREG=32, then poll ready.
  - ready = 0 for exactly 31 cycles, then 1.
  - Reading any register returns 0.
  - Writes issued during INIT are lost; reading x5 after ready returns 0.
- Dual-write collision: port0 writes x7 = 0x11111111 and port1 writes x7 = 0x22222222 in the same cycle.
  - Next cycle a read of x7 returns 0x22222222.
- Register 0: write x0 = 0xDEADBEEF and claim x0.
  - A read of x0 returns 0 with rd_busy = 0.
- Scoreboard:
  - Claim x3: rd_busy for x3 is 0 in the claim cycle and 1 on the following cycle.
  - Write x3 = 0x5: rd_busy for x3 returns to 0.
  - Claim and write x3 in the same cycle: busy stays 1.
- Bypass: write x9 = 0xCAFEF00D and read x9 on both ports in the same cycle.
  - With REGFILE_BYPASS_EN: both ports return 0xCAFEF00D with busy 0 in that cycle.
  - Without it: both ports return the old value, and 0xCAFEF00D one cycle later.
- Mid-operation reset: assert rst while x4 is busy and holds 0x44.
  - rd_busy drops to 0 on the next edge.
  - ready falls to 0.
  - After the sweep, a read of x4 returns 0.
